// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm clock UI / ring sequencing block.
package alarm_pkg;

  // User-interface edit states: run, then clock hour/minute, then alarm hour/minute.
  typedef enum logic [2:0] {
    UI_RUN   = 3'd0,
    UI_T_HR  = 3'd1,
    UI_T_MIN = 3'd2,
    UI_A_HR  = 3'd3,
    UI_A_MIN = 3'd4
  } ui_state_t;

  // Ring sequencer states.
  typedef enum logic [1:0] {
    RS_IDLE    = 2'd0,
    RS_RINGING = 2'd1,
    RS_SNOOZED = 2'd2
  } ring_state_t;

  // Wrap points of the edit registers.
  localparam logic [4:0] HR_MAX  = 5'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;

  // Two BCD digits of a 0..63 binary value.
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_t;

  // Split a binary value (0..59 in practice) into tens and units digits.
  function automatic bcd_t bcd_split(input logic [5:0] value);
    bcd_t       result;
    logic [5:0] quot;
    logic [5:0] rem;
    quot         = value / 6'd10;
    rem          = value - quot * 6'd10;
    result.tens  = 4'(quot);
    result.units = 4'(rem);
    return result;
  endfunction

endpackage

// File: rtl/alarm_ctrl_ring_seq.sv
// Ring / snooze sequencer: starts ringing on an armed alarm rising edge,
// auto-stops after RING_SECS, handles a bounded number of snoozes and
// issues a one-cycle stop pulse whenever ringing ends or pauses.
module ring_seq
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic sec_tick,
  input  logic alarm,
  input  logic arm_en,
  input  logic snooze_req,
  input  logic stop_req,
  output logic ring,
  output logic stop
);

  localparam int RW = $clog2(RING_SECS + 1);
  localparam int TW = $clog2(SNOOZE_SECS + 1);
  localparam int SW = $clog2(MAX_SNOOZE + 1);

  localparam logic [RW-1:0] RING_LAST    = RW'(RING_SECS - 1);
  localparam logic [TW-1:0] SNOOZE_LOAD  = TW'(SNOOZE_SECS);
  localparam logic [TW-1:0] TIMER_ONE    = TW'(1);
  localparam logic [SW-1:0] SNOOZE_LIMIT = SW'(MAX_SNOOZE);

  ring_state_t   state, state_next;
  logic [RW-1:0] ring_cnt, ring_cnt_next;
  logic [TW-1:0] timer, timer_next;
  logic [SW-1:0] snooze_cnt, snooze_cnt_next;
  logic          alarm_q;
  logic          rise;
  logic          ring_d, stop_d;

  assign rise = alarm && !alarm_q;

  // State register, counters, edge detector and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RS_IDLE;
      ring_cnt   <= '0;
      timer      <= '0;
      snooze_cnt <= '0;
      alarm_q    <= 1'b0;
      ring       <= 1'b0;
      stop       <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values;
      // blocking = here would make results depend on statement order.
      state      <= state_next;
      ring_cnt   <= ring_cnt_next;
      timer      <= timer_next;
      snooze_cnt <= snooze_cnt_next;
      alarm_q    <= alarm;
      ring       <= ring_d;
      stop       <= stop_d;
    end
  end

  // Next-state and counter update; stop requests beat snooze and timer expiry.
  always_comb begin
    // NOTE: defaults first so every path assigns every variable; otherwise a
    // missing branch would infer a latch.
    state_next      = state;
    ring_cnt_next   = ring_cnt;
    timer_next      = timer;
    snooze_cnt_next = snooze_cnt;
    case (state)
      RS_IDLE: begin
        if (rise && arm_en) begin
          state_next      = RS_RINGING;
          ring_cnt_next   = '0;
          snooze_cnt_next = '0;
        end
      end
      RS_RINGING: begin
        if (stop_req || (snooze_req && snooze_cnt >= SNOOZE_LIMIT)) begin
          state_next = RS_IDLE;
        end else if (snooze_req) begin
          state_next      = RS_SNOOZED;
          snooze_cnt_next = snooze_cnt + 1'b1;
          timer_next      = SNOOZE_LOAD;
        end else if (sec_tick) begin
          if (ring_cnt == RING_LAST) begin
            state_next = RS_IDLE;
          end else begin
            ring_cnt_next = ring_cnt + 1'b1;
          end
        end
      end
      RS_SNOOZED: begin
        if (stop_req) begin
          state_next = RS_IDLE;
        end else if (sec_tick) begin
          if (timer == TIMER_ONE) begin
            state_next    = RS_RINGING;
            ring_cnt_next = '0;
            timer_next    = '0;
          end else begin
            timer_next = timer - 1'b1;
          end
        end
      end
      default: state_next = RS_IDLE;
    endcase
  end

  // Output decode: ring follows the next state; stop fires whenever an active
  // state is left for anything other than ringing.
  always_comb begin
    ring_d = (state_next == RS_RINGING);
    stop_d = (state != RS_IDLE) && (state_next != state) && (state_next != RS_RINGING);
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock UI controller: turns debounced button pulses into BCD load
// values and time_set/alarm_set pulses, tracks the alarm enable, and hands
// ring/snooze sequencing to ring_seq.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SECS    = 60,
  parameter int SNOOZE_SECS  = 300,
  parameter int MAX_SNOOZE   = 3,
  parameter int EDIT_TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_arm,
  input  logic       btn_snooze,
  input  logic       btn_stop,
  input  logic       alarm,
  output logic [1:0] hour_in1,
  output logic [3:0] hour_in0,
  output logic [3:0] min_in1,
  output logic [3:0] min_in0,
  output logic       time_set,
  output logic       alarm_set,
  output logic       alarm_on,
  output logic       stop,
  output logic       ring,
  output logic [1:0] edit_field,
  output logic       edit_alarm
);

  localparam int             IW        = $clog2(EDIT_TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(EDIT_TIMEOUT - 1);

  ui_state_t     state, state_next;
  logic [4:0]    hr;
  logic [5:0]    mn;
  logic [IW-1:0] idle_cnt;
  logic          any_btn;
  logic          edit_active;
  logic          timeout;
  logic          time_set_d, alarm_set_d;
  logic          stop_req;
  bcd_t          hr_bcd, mn_bcd;

  assign any_btn     = btn_mode | btn_inc | btn_arm | btn_snooze | btn_stop;
  assign edit_active = (state != UI_RUN);
  assign timeout     = edit_active && !any_btn && sec_tick && (idle_cnt == IDLE_LAST);

  // Disarming while ringing or snoozed ends the alarm just like btn_stop.
  assign stop_req = btn_stop | (btn_arm & alarm_on);

  // UI state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= UI_RUN;
    end else begin
      state <= state_next;
    end
  end

  // UI next state: mode walks the fields; an idle timeout abandons the edit.
  always_comb begin
    state_next = state;
    case (state)
      UI_RUN:   if (btn_mode) state_next = UI_T_HR;
      UI_T_HR:  if (btn_mode) state_next = UI_T_MIN; else if (timeout) state_next = UI_RUN;
      UI_T_MIN: if (btn_mode) state_next = UI_A_HR;  else if (timeout) state_next = UI_RUN;
      UI_A_HR:  if (btn_mode) state_next = UI_A_MIN; else if (timeout) state_next = UI_RUN;
      UI_A_MIN: if (btn_mode) state_next = UI_RUN;   else if (timeout) state_next = UI_RUN;
      default:  state_next = UI_RUN;
    endcase
  end

  // UI outputs: field indicators from the state, commit strobes on leaving a minute field.
  always_comb begin
    edit_field  = 2'd0;
    edit_alarm  = 1'b0;
    time_set_d  = 1'b0;
    alarm_set_d = 1'b0;
    case (state)
      UI_T_HR:  edit_field = 2'd1;
      UI_T_MIN: begin
        edit_field = 2'd2;
        time_set_d = btn_mode;
      end
      UI_A_HR: begin
        edit_field = 2'd1;
        edit_alarm = 1'b1;
      end
      UI_A_MIN: begin
        edit_field  = 2'd2;
        edit_alarm  = 1'b1;
        alarm_set_d = btn_mode;
      end
      default: ;
    endcase
  end

  // Load strobes are registered so they line up with the committed digits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      time_set  <= 1'b0;
      alarm_set <= 1'b0;
    end else begin
      time_set  <= time_set_d;
      alarm_set <= alarm_set_d;
    end
  end

  // Edit registers: increment the active field with wrap; mode pressed in
  // the same cycle takes precedence and the increment is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hr <= '0;
      mn <= '0;
    end else if (btn_inc && !btn_mode) begin
      if (edit_field == 2'd1) begin
        hr <= (hr == HR_MAX) ? '0 : hr + 1'b1;
      end else if (edit_field == 2'd2) begin
        mn <= (mn == MIN_MAX) ? '0 : mn + 1'b1;
      end
    end
  end

  // Idle counter: seconds without a button press while editing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (!edit_active || any_btn || timeout) begin
      idle_cnt <= '0;
    end else if (sec_tick) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Alarm enable toggles on every arm press, in any UI state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_on <= 1'b0;
    end else if (btn_arm) begin
      alarm_on <= !alarm_on;
    end
  end

  // Digits presented to the datapath are a plain BCD view of the edit registers.
  assign hr_bcd   = bcd_split({1'b0, hr});
  assign mn_bcd   = bcd_split(mn);
  assign hour_in1 = 2'(hr_bcd.tens);
  assign hour_in0 = hr_bcd.units;
  assign min_in1  = mn_bcd.tens;
  assign min_in0  = mn_bcd.units;

  ring_seq #(
    .RING_SECS  (RING_SECS),
    .SNOOZE_SECS(SNOOZE_SECS),
    .MAX_SNOOZE (MAX_SNOOZE)
  ) u_ring_seq (
    .clk       (clk),
    .reset     (reset),
    .sec_tick  (sec_tick),
    .alarm     (alarm),
    .arm_en    (alarm_on),
    .snooze_req(btn_snooze),
    .stop_req  (stop_req),
    .ring      (ring),
    .stop      (stop)
  );

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: edit sequencing, wrap, timeout, ring,
// snooze, stop priority, disarm and asynchronous reset.
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sec_tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_arm = 1'b0;
  logic       btn_snooze = 1'b0;
  logic       btn_stop = 1'b0;
  logic       alarm = 1'b0;
  logic [1:0] hour_in1;
  logic [3:0] hour_in0;
  logic [3:0] min_in1;
  logic [3:0] min_in0;
  logic       time_set;
  logic       alarm_set;
  logic       alarm_on;
  logic       stop;
  logic       ring;
  logic [1:0] edit_field;
  logic       edit_alarm;

  int n_checks = 0;
  int n_pass = 0;
  int ts_cnt = 0;
  int as_cnt = 0;
  int stop_cnt = 0;
  int overlap_cnt = 0;
  int s0;

  alarm_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .sec_tick  (sec_tick),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .btn_arm   (btn_arm),
    .btn_snooze(btn_snooze),
    .btn_stop  (btn_stop),
    .alarm     (alarm),
    .hour_in1  (hour_in1),
    .hour_in0  (hour_in0),
    .min_in1   (min_in1),
    .min_in0   (min_in0),
    .time_set  (time_set),
    .alarm_set (alarm_set),
    .alarm_on  (alarm_on),
    .stop      (stop),
    .ring      (ring),
    .edit_field(edit_field),
    .edit_alarm(edit_alarm)
  );

  always #5 clk = ~clk;

  // Count output pulses shortly after each active edge.
  always @(posedge clk) begin
    #2;
    if (time_set) ts_cnt++;
    if (alarm_set) as_cnt++;
    if (stop) stop_cnt++;
    if (time_set && alarm_set) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One-cycle button pulse; starts and ends just after a falling edge.
  task automatic press(input logic m, input logic i, input logic a, input logic s, input logic p);
    btn_mode = m; btn_inc = i; btn_arm = a; btn_snooze = s; btn_stop = p;
    @(negedge clk);
    btn_mode = 0; btn_inc = 0; btn_arm = 0; btn_snooze = 0; btn_stop = 0;
  endtask

  task automatic press_n(input logic m, input logic i, input int n);
    for (int k = 0; k < n; k++) press(m, i, 0, 0, 0);
  endtask

  // n second ticks two cycles apart; returns right after the last tick's edge.
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      sec_tick = 1'b1;
      @(negedge clk);
      sec_tick = 1'b0;
      if (k != n - 1) @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_ring", ring, 0);
    check("rst_stop", stop, 0);
    check("rst_time_set", time_set, 0);
    check("rst_alarm_set", alarm_set, 0);
    check("rst_alarm_on", alarm_on, 0);
    check("rst_edit_field", edit_field, 0);
    check("rst_digits", {hour_in1, hour_in0, min_in1, min_in0}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Clock time edit: 07:45
    press(1, 0, 0, 0, 0);
    check("t_hr_field", edit_field, 1);
    check("t_hr_alarm", edit_alarm, 0);
    press_n(0, 1, 7);
    check("hr7_digits", {hour_in1, hour_in0}, {2'd0, 4'd7});
    press(1, 0, 0, 0, 0);
    check("t_min_field", edit_field, 2);
    press_n(0, 1, 45);
    check("mn45_digits", {min_in1, min_in0}, {4'd4, 4'd5});
    press(1, 0, 0, 0, 0);
    check("time_set_pulse", time_set, 1);
    check("commit_digits", {hour_in1, hour_in0, min_in1, min_in0}, {2'd0, 4'd7, 4'd4, 4'd5});
    check("a_hr_field", {edit_alarm, edit_field}, {1'b1, 2'd1});
    @(negedge clk);
    check("time_set_drop", time_set, 0);
    check("time_set_count", ts_cnt, 1);

    // Alarm edit: hour wrap 23->0, mode+inc, minute wrap 59->0
    press_n(0, 1, 16);
    check("hr23_digits", {hour_in1, hour_in0}, {2'd2, 4'd3});
    press(0, 1, 0, 0, 0);
    check("hr_wrap", {hour_in1, hour_in0}, 0);
    press(1, 1, 0, 0, 0);
    check("mode_inc_field", edit_field, 2);
    check("mode_inc_value", {hour_in1, hour_in0, min_in1, min_in0}, {2'd0, 4'd0, 4'd4, 4'd5});
    press_n(0, 1, 14);
    check("mn59_digits", {min_in1, min_in0}, {4'd5, 4'd9});
    press(0, 1, 0, 0, 0);
    check("mn_wrap", {min_in1, min_in0}, 0);
    press(1, 0, 0, 0, 0);
    check("alarm_set_pulse", alarm_set, 1);
    check("run_field", edit_field, 0);
    @(negedge clk);
    check("alarm_set_count", as_cnt, 1);

    // Edit timeout
    press(1, 0, 0, 0, 0);
    ticks(29);
    check("timeout_29", edit_field, 1);
    ticks(1);
    check("timeout_30", edit_field, 0);
    @(negedge clk);
    check("timeout_no_pulse", {ts_cnt, as_cnt}, {32'd1, 32'd1});

    // Ring with auto-stop
    press(0, 0, 1, 0, 0);
    check("armed", alarm_on, 1);
    s0 = stop_cnt;
    alarm = 1'b1;
    @(negedge clk);
    check("ring_start", ring, 1);
    ticks(59);
    check("ring_59", ring, 1);
    ticks(1);
    check("ring_auto_off", ring, 0);
    check("auto_stop_pulse", stop, 1);
    alarm = 1'b0;
    @(negedge clk);
    check("auto_stop_drop", stop, 0);
    check("auto_stop_count", stop_cnt - s0, 1);

    // Three snoozes then a fourth acting as stop
    s0 = stop_cnt;
    alarm = 1'b1;
    @(negedge clk);
    alarm = 1'b0;
    check("ring_again", ring, 1);
    for (int k = 0; k < 3; k++) begin
      press(0, 0, 0, 1, 0);
      check("snooze_ring_off", ring, 0);
      check("snooze_stop", stop, 1);
      ticks(299);
      check("snooze_299", ring, 0);
      ticks(1);
      check("snooze_rering", ring, 1);
    end
    press(0, 0, 0, 1, 0);
    check("snooze4_ring_off", ring, 0);
    check("snooze4_stop", stop, 1);
    ticks(305);
    check("snooze4_stays_off", ring, 0);
    check("snooze_stop_count", stop_cnt - s0, 4);

    // Stop and snooze together: stop wins
    alarm = 1'b1;
    @(negedge clk);
    alarm = 1'b0;
    check("ring_third", ring, 1);
    press(0, 0, 0, 1, 1);
    check("stop_snooze_ring", ring, 0);
    check("stop_snooze_pulse", stop, 1);
    ticks(301);
    check("stop_wins_idle", ring, 0);

    // Disarm while ringing acts as stop; disarmed alarm does not ring
    alarm = 1'b1;
    @(negedge clk);
    check("ring_fourth", ring, 1);
    press(0, 0, 1, 0, 0);
    check("disarm_level", alarm_on, 0);
    check("disarm_ring", ring, 0);
    check("disarm_stop", stop, 1);
    alarm = 1'b0;
    @(negedge clk);
    alarm = 1'b1;
    @(negedge clk);
    check("disarmed_no_ring", ring, 0);
    alarm = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-ring
    press(0, 0, 1, 0, 0);
    alarm = 1'b1;
    @(negedge clk);
    check("ring_before_reset", ring, 1);
    #2;
    reset = 1'b0;
    #1;
    check("reset_ring_async", ring, 0);
    check("reset_alarm_on_async", alarm_on, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_outputs",
          {ring, stop, time_set, alarm_set, alarm_on, edit_field, edit_alarm}, 0);
    check("post_reset_digits", {hour_in1, hour_in0, min_in1, min_in0}, 0);
    alarm = 1'b0;
    @(negedge clk);
    alarm = 1'b1;
    @(negedge clk);
    check("post_reset_idle", ring, 0);
    check("never_overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
